lifo_arbiter: RTL and testbench

Controller that shares one 8-bit LIFO between two requesters. It arbitrates push/pop requests, sequences the LIFO control pins (EN, PUSH_POP, W_EN, RW) and the bidirectional IO bus, and returns pop data and completion or error status over a per-requester REQ/ACK handshake. It sits directly in front of the LIFO instance; requesters never touch the LIFO pins.

---
 rtl/lifo_arb_pkg.sv | 18 +
 rtl/lifo_arbiter_rr_arb2.sv | 38 +++
 rtl/lifo_arbiter.sv | 121 ++++++++++++
 tb/tb_lifo_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_arb_pkg.sv
// Shared types and constants for the two-requester LIFO arbiter.
// Arbitration policy is selected by LIFO_ARB_RR_EN (see rr_arb2).
package lifo_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/lifo_arbiter_rr_arb2.sv
// Two-way grant. With LIFO_ARB_RR_EN defined a last-grant pointer breaks ties;
// otherwise requester 0 always wins and the pointer does not exist.
module rr_arb2 (
`ifdef LIFO_ARB_RR_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       take,
`endif
    input  logic [1:0] req,
    output logic       gnt
);

`ifdef LIFO_ARB_RR_EN
    logic last;

    // Reset to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b1;
        else if (take)
            last <= gnt;
    end

    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end
`else
    always_comb begin
        gnt = (req == 2'b10);
    end
`endif

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between two requesters: FSM, request latches, IO tri-state.
// Tie-break policy is chosen by LIFO_ARB_RR_EN (round-robin when defined).
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        REQ,
    input  logic [1:0]        OP,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic [1:0]        ACK,
    output logic [1:0]        ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic              EN,
    output logic              PUSH_POP,
    output logic              W_EN,
    output logic              RW,
    inout  wire  [DATA_W-1:0] IO,
    input  logic              FULL,
    input  logic              EMPTY
);

    state_t            state, state_nxt;
    logic              gnt;
    logic              reject;
    logic              take;
    logic              id;
    logic              op;
    logic              err;
    logic [DATA_W-1:0] wdata;
    logic              io_drive;

    assign take = (state == S_IDLE) && (|REQ);

    rr_arb2 u_arb (
`ifdef LIFO_ARB_RR_EN
        .clk   (CLK),
        .reset (RESET),
        .take  (take),
`endif
        .req   (REQ),
        .gnt   (gnt)
    );

    always_comb begin
        reject = (OP[gnt] == OP_PUSH) ? FULL : EMPTY;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (|REQ) state_nxt = reject ? S_RESP : S_SETUP;
            S_SETUP:   state_nxt = S_STROBE;
            S_STROBE:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The winner's request is frozen here so requesters may change inputs after ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            id    <= 1'b0;
            op    <= OP_POP;
            err   <= 1'b0;
            wdata <= '0;
            RDATA <= '0;
        end else begin
            if (take) begin
                id    <= gnt;
                op    <= OP[gnt];
                err   <= reject;
                wdata <= gnt ? WDATA1 : WDATA0;
            end
            if (state == S_CAPTURE && op == OP_POP)
                RDATA <= IO;
        end
    end

    // Pin outputs decode only the state and latched request, never REQ/FULL/EMPTY.
    always_comb begin
        EN       = 1'b0;
        PUSH_POP = 1'b1;
        W_EN     = 1'b0;
        RW       = 1'b0;
        ACK      = 2'b00;
        ERR      = 2'b00;
        case (state)
            S_SETUP, S_STROBE: begin
                EN       = 1'b1;
                PUSH_POP = op;
                W_EN     = (op == OP_PUSH);
                RW       = (state == S_STROBE);
            end
            S_CAPTURE: begin
                EN       = 1'b1;
                PUSH_POP = op;
            end
            S_RESP: begin
                ACK[id] = 1'b1;
                ERR[id] = err;
            end
            default: ;
        endcase
    end

    assign io_drive = (state == S_SETUP || state == S_STROBE) && (op == OP_PUSH);
    assign IO       = io_drive ? wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter with a 4-deep LIFO bus model and a
// queue-based reference; expectations follow LIFO_ARB_RR_EN when it is defined.
module tb_lifo_arbiter;

`ifdef LIFO_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] REQ, OP;
    logic [7:0] WDATA0, WDATA1;
    wire  [1:0] ACK, ERR;
    wire  [7:0] RDATA;
    wire        EN, PUSH_POP, W_EN, RW;
    wire  [7:0] IO;
    wire        FULL, EMPTY;

    lifo_arbiter #(.DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .OP(OP),
        .WDATA0(WDATA0), .WDATA1(WDATA1), .ACK(ACK), .ERR(ERR),
        .RDATA(RDATA), .EN(EN), .PUSH_POP(PUSH_POP), .W_EN(W_EN),
        .RW(RW), .IO(IO), .FULL(FULL), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    // LIFO device model driven purely by the pins.
    int         cnt = 0;
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] lifo_out = 8'h00;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_pat = 8'h00;

    always @(posedge CLK) begin
        if (RESET) begin
            cnt      <= 0;
            lifo_out <= 8'h00;
        end else if (EN && RW) begin
            if (!PUSH_POP && W_EN && cnt < DEPTH) begin
                mem[cnt] <= IO;
                cnt      <= cnt + 1;
            end else if (PUSH_POP && cnt > 0) begin
                lifo_out <= mem[cnt-1];
                cnt      <= cnt - 1;
            end
        end
    end

    assign IO    = (EN && PUSH_POP) ? lifo_out : (tb_drv ? tb_pat : 8'hzz);
    assign FULL  = (cnt == DEPTH);
    assign EMPTY = (cnt == 0);

    // Reference model
    logic [7:0] ref_stack[$];
    logic       ref_last;
    int         checks = 0;
    int         passes = 0;

    function automatic logic pick(input logic [1:0] r);
        if (r == 2'b11) return RR ? ~ref_last : 1'b0;
        return (r == 2'b10);
    endfunction

    task automatic ref_grant(input logic [1:0] r, input logic [1:0] ops,
                             input logic [7:0] d0, input logic [7:0] d1,
                             output logic w, output logic e, output logic [7:0] pd);
        w  = pick(r);
        ref_last = w;
        pd = 8'h00;
        e  = 1'b0;
        if (ops[w] == 1'b0) begin
            if (ref_stack.size() == DEPTH) e = 1'b1;
            else ref_stack.push_back(w ? d1 : d0);
        end else begin
            if (ref_stack.size() == 0) e = 1'b1;
            else pd = ref_stack.pop_back();
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; REQ = 2'b00; OP = 2'b00; WDATA0 = 8'h00; WDATA1 = 8'h00;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        ref_stack.delete();
        ref_last = 1'b1;
    endtask

    // Drives a request set, waits (bounded) for ACK; returns at the following IDLE cycle.
    task automatic txn(input logic [1:0] r, input logic [1:0] ops,
                       input logic [7:0] d0, input logic [7:0] d1, input bit keep,
                       output int lat, output logic [1:0] ack, output logic [1:0] err,
                       output logic [7:0] rd, output logic pins);
        REQ = r; OP = ops; WDATA0 = d0; WDATA1 = d1;
        lat = 0; ack = 2'b00; err = 2'b00; rd = 8'h00; pins = 1'b0;
        while (lat < 12) begin
            @(posedge CLK); #1;
            lat++;
            if (EN || RW || W_EN) pins = 1'b1;
            if (ACK != 2'b00) begin
                ack = ACK; err = ERR; rd = RDATA;
                break;
            end
        end
        if (!keep) REQ = REQ & ~ack;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        tb_drv = 1'b1; tb_pat = 8'h5A;
        #1;
        checks++; if (EN !== 1'b0) $display("FAIL reset_en got %b want 0", EN); else passes++;
        checks++; if (PUSH_POP !== 1'b1) $display("FAIL reset_push_pop got %b want 1", PUSH_POP); else passes++;
        checks++; if (W_EN !== 1'b0) $display("FAIL reset_w_en got %b want 0", W_EN); else passes++;
        checks++; if (RW !== 1'b0) $display("FAIL reset_rw got %b want 0", RW); else passes++;
        checks++; if (ACK !== 2'b00) $display("FAIL reset_ack got %b want 00", ACK); else passes++;
        checks++; if (ERR !== 2'b00) $display("FAIL reset_err got %b want 00", ERR); else passes++;
        checks++; if (RDATA !== 8'h00) $display("FAIL reset_rdata got %h want 00", RDATA); else passes++;
        checks++; if (IO !== 8'h5A) $display("FAIL reset_io_released got %h want 5a", IO); else passes++;
        tb_drv = 1'b0;
    endtask

    task automatic test_push_timing();
        logic w, e; logic [7:0] pd;
        do_reset();
        REQ = 2'b01; OP = 2'b00; WDATA0 = 8'hA5;
        ref_grant(2'b01, 2'b00, 8'hA5, 8'h00, w, e, pd);
        @(posedge CLK); #1;
        checks++; if ({EN, PUSH_POP, W_EN, RW} !== 4'b1010)
            $display("FAIL setup_pins got EN/PP/WE/RW=%b want 1010", {EN, PUSH_POP, W_EN, RW}); else passes++;
        checks++; if (IO !== 8'hA5) $display("FAIL setup_io got %h want a5", IO); else passes++;
        @(posedge CLK); #1;
        checks++; if (RW !== 1'b1 || IO !== 8'hA5)
            $display("FAIL strobe got RW=%b IO=%h want RW=1 IO=a5", RW, IO); else passes++;
        @(posedge CLK); #1;
        checks++; if ({EN, RW, W_EN} !== 3'b100)
            $display("FAIL capture_pins got EN/RW/WE=%b want 100", {EN, RW, W_EN}); else passes++;
        @(posedge CLK); #1;
        checks++; if (ACK !== 2'b01 || ERR !== 2'b00)
            $display("FAIL push_ack got ACK=%b ERR=%b want 01/00", ACK, ERR); else passes++;
        REQ = 2'b00;
        @(posedge CLK); #1;
        checks++; if (ACK !== 2'b00) $display("FAIL ack_one_cycle got %b want 00", ACK); else passes++;
    endtask

    task automatic test_push_pop();
        logic w, e; logic [7:0] pd, rd; logic [1:0] ack, err; int lat; logic pins;
        logic [7:0] want [2] = '{8'h22, 8'h11};
        ref_grant(2'b01, 2'b00, 8'h11, 8'h00, w, e, pd);
        txn(2'b01, 2'b00, 8'h11, 8'h00, 1'b0, lat, ack, err, rd, pins);
        ref_grant(2'b01, 2'b00, 8'h22, 8'h00, w, e, pd);
        txn(2'b01, 2'b00, 8'h22, 8'h00, 1'b0, lat, ack, err, rd, pins);
        checks++; if (ack !== 2'b01 || err !== 2'b00 || lat != 4)
            $display("FAIL push22 got ack=%b err=%b lat=%0d want 01/00/4", ack, err, lat); else passes++;
        for (int i = 0; i < 2; i++) begin
            ref_grant(2'b10, 2'b10, 8'h00, 8'h00, w, e, pd);
            txn(2'b10, 2'b10, 8'h00, 8'h00, 1'b0, lat, ack, err, rd, pins);
            checks++; if (ack !== 2'b10 || err !== 2'b00 || rd !== want[i] || rd !== pd)
                $display("FAIL pop%0d got ack=%b err=%b rdata=%h want 10/00/%h", i, ack, err, rd, want[i]);
            else passes++;
        end
    endtask

    task automatic test_pop_empty();
        logic w, e; logic [7:0] pd, rd; logic [1:0] ack, err; int lat; logic pins;
        do_reset();
        ref_grant(2'b01, 2'b00, 8'h5C, 8'h00, w, e, pd);
        txn(2'b01, 2'b00, 8'h5C, 8'h00, 1'b0, lat, ack, err, rd, pins);
        ref_grant(2'b10, 2'b10, 8'h00, 8'h00, w, e, pd);
        txn(2'b10, 2'b10, 8'h00, 8'h00, 1'b0, lat, ack, err, rd, pins);
        checks++; if (rd !== 8'h5C) $display("FAIL pop_5c got %h want 5c", rd); else passes++;
        ref_grant(2'b10, 2'b10, 8'h00, 8'h00, w, e, pd);
        txn(2'b10, 2'b10, 8'h00, 8'h00, 1'b0, lat, ack, err, rd, pins);
        checks++; if (ack !== 2'b10 || err !== 2'b10 || lat != 1)
            $display("FAIL pop_empty got ack=%b err=%b lat=%0d want 10/10/1", ack, err, lat); else passes++;
        checks++; if (pins !== 1'b0 || rd !== 8'h5C)
            $display("FAIL pop_empty_quiet got pins=%b rdata=%h want 0/5c", pins, rd); else passes++;
    endtask

    task automatic test_full();
        logic w, e; logic [7:0] pd, rd, d; logic [1:0] ack, err; int lat; logic pins;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom);
            ref_grant(2'b10, 2'b00, 8'h00, d, w, e, pd);
            txn(2'b10, 2'b00, 8'h00, d, 1'b0, lat, ack, err, rd, pins);
        end
        ref_grant(2'b01, 2'b00, 8'hEE, 8'h00, w, e, pd);
        txn(2'b01, 2'b00, 8'hEE, 8'h00, 1'b0, lat, ack, err, rd, pins);
        checks++; if (ack !== 2'b01 || err !== 2'b01 || lat != 1 || e !== 1'b1)
            $display("FAIL push_full got ack=%b err=%b lat=%0d want 01/01/1", ack, err, lat); else passes++;
        checks++; if (pins !== 1'b0) $display("FAIL push_full_quiet got pins=%b want 0", pins); else passes++;
    endtask

    task automatic test_back_to_back();
        logic w, e; logic [7:0] pd, rd, d0, d1; logic [1:0] ack, err; int lat; logic pins;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d0 = 8'($urandom); d1 = 8'($urandom);
            ref_grant(2'b11, 2'b00, d0, d1, w, e, pd);
            txn(2'b11, 2'b00, d0, d1, 1'b1, lat, ack, err, rd, pins);
            checks++; if (ack !== (2'b01 << w) || err !== ({1'b0, e} << w) || lat != (e ? 1 : 4))
                $display("FAIL b2b%0d got ack=%b err=%b lat=%0d want winner %0d err %b",
                         i, ack, err, lat, w, e);
            else passes++;
        end
        REQ = 2'b00;
    endtask

    task automatic test_reset_strobe();
        int acks = 0;
        do_reset();
        REQ = 2'b01; OP = 2'b00; WDATA0 = 8'h3C;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++; if (RW !== 1'b1) $display("FAIL pre_reset_strobe got RW=%b want 1", RW); else passes++;
        RESET = 1'b1;
        @(posedge CLK); #1;
        tb_drv = 1'b1; tb_pat = 8'hC3; #1;
        checks++; if ({EN, PUSH_POP, W_EN, RW, ACK} !== 6'b010000 || IO !== 8'hC3)
            $display("FAIL reset_in_strobe got EN/PP/WE/RW/ACK=%b IO=%h want 010000 c3",
                     {EN, PUSH_POP, W_EN, RW, ACK}, IO);
        else passes++;
        tb_drv = 1'b0;
        RESET = 1'b0; REQ = 2'b00;
        ref_stack.delete(); ref_last = 1'b1;
        repeat (6) begin
            @(posedge CLK); #1;
            if (ACK != 2'b00) acks++;
        end
        checks++; if (acks != 0) $display("FAIL no_ack_after_reset got %0d acks want 0", acks); else passes++;
    endtask

    task automatic test_random();
        logic w, e; logic [7:0] pd, rd; logic [1:0] ack, err; int lat; logic pins;
        logic [1:0] pend = 2'b00, ops = 2'b00;
        logic [7:0] d [2] = '{8'h00, 8'h00};
        do_reset();
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1; ops[i] = 1'($urandom); d[i] = 8'($urandom);
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1; ops[0] = 1'($urandom); d[0] = 8'($urandom);
            end
            ref_grant(pend, ops, d[0], d[1], w, e, pd);
            txn(pend, ops, d[0], d[1], 1'b0, lat, ack, err, rd, pins);
            checks++;
            if (ack !== (2'b01 << w) || err !== ({1'b0, e} << w) || lat != (e ? 1 : 4) ||
                (ops[w] && !e && rd !== pd))
                $display("FAIL rand%0d req=%b op=%b got ack=%b err=%b lat=%0d rdata=%h want winner %0d err %b rdata %h",
                         t, pend, ops, ack, err, lat, rd, w, e, pd);
            else passes++;
            pend[w] = 1'b0;
        end
        REQ = 2'b00;
    endtask

    initial begin
        test_reset();
        test_push_timing();
        test_push_pop();
        test_pop_empty();
        test_full();
        test_back_to_back();
        test_reset_strobe();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired passed=%0d checks=%0d", passes, checks);
        $fatal(1);
    end

endmodule
